// File: rtl/mem_stage_pkg.sv
// Shared types and sizing helpers for the MEM pipeline stage.
package mem_stage_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_GNT = 2'd1,
    WAIT_RSP = 2'd2
  } state_e;

  localparam int unsigned TIMEOUT_DEF = 255;

  function automatic int unsigned wait_cnt_w(input int unsigned timeout);
    return $clog2(timeout + 1);
  endfunction

  localparam int unsigned WAIT_CNT_W = wait_cnt_w(TIMEOUT_DEF);

endpackage

// File: rtl/mem_wait_timer.sv
// Wait-cycle counter for outstanding memory accesses; expired_o flags count==TIMEOUT.
module mem_wait_timer
  import mem_stage_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEF,
  parameter int unsigned CNT_W   = WAIT_CNT_W
) (
  input  logic clk,
  input  logic rst_i,
  input  logic clear_i,
  input  logic en_i,
  output logic expired_o
);

  logic [CNT_W-1:0] count_q, count_d;

  assign expired_o = (count_q == CNT_W'(TIMEOUT));

  // Holds at TIMEOUT so the compare can never wrap back to a live count.
  always_comb begin
    count_d = count_q;
    if (clear_i)
      count_d = '0;
    else if (en_i && !expired_o)
      count_d = count_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst_i) count_q <= '0;
    else       count_q <= count_d;
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: drives the data-memory req/gnt/rvalid handshake and stalls upstream
// while an access is outstanding; stalled cycles are presented to MEM/WB as bubbles.
module mem_access_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              MemRead_i,
  input  logic              MemWrite_i,
  input  logic              RegWrite_i,
  input  logic              MemtoReg_i,
  input  logic [31:0]       alu_result_i,
  input  logic [DATA_W-1:0] write_data_i,
  input  logic [4:0]        write_addr_i,
  output logic              dmem_req_o,
  output logic              dmem_we_o,
  output logic [ADDR_W-1:0] dmem_addr_o,
  output logic [DATA_W-1:0] dmem_wdata_o,
  input  logic              dmem_gnt_i,
  input  logic              dmem_rvalid_i,
  input  logic [DATA_W-1:0] dmem_rdata_i,
  output logic              stall_o,
  output logic              RegWrite_o,
  output logic [31:0]       alu_result_o,
  output logic [DATA_W-1:0] read_data_o,
  output logic [4:0]        write_addr_o,
  output logic              MemtoReg_o,
  output logic              misalign_o,
  output logic              timeout_o
);

  localparam int unsigned CntW = wait_cnt_w(TIMEOUT);

  state_e state_q, state_d;
  logic   timeout_q;
  logic   is_mem, aligned, expired, clear, abort;

  assign is_mem  = MemRead_i | MemWrite_i;
  assign aligned = (alu_result_i[1:0] == 2'b00);

  // rst_n is active-high: the pin name is inherited, the polarity is not.
  always_comb begin
    state_d     = state_q;
    dmem_req_o  = 1'b0;
    stall_o     = 1'b0;
    RegWrite_o  = 1'b0;
    read_data_o = '0;
    misalign_o  = 1'b0;
    abort       = 1'b0;
    clear       = 1'b1;
    case (state_q)
      IDLE: begin
        if (is_mem && aligned) begin
          dmem_req_o = 1'b1;
          if (dmem_gnt_i) begin
            if (MemWrite_i) begin
              RegWrite_o = RegWrite_i;
            end else begin
              stall_o = 1'b1;
              state_d = WAIT_RSP;
            end
          end else begin
            stall_o = 1'b1;
            state_d = WAIT_GNT;
          end
        end else if (is_mem) begin
          misalign_o = 1'b1;
        end else begin
          RegWrite_o = RegWrite_i;
        end
      end
      WAIT_GNT: begin
        dmem_req_o = 1'b1;
        if (dmem_gnt_i) begin
          if (MemWrite_i) begin
            RegWrite_o = RegWrite_i;
            state_d    = IDLE;
          end else begin
            stall_o = 1'b1;
            state_d = WAIT_RSP;
          end
        end else if (expired) begin
          abort   = 1'b1;
          state_d = IDLE;
        end else begin
          stall_o = 1'b1;
          clear   = 1'b0;
        end
      end
      WAIT_RSP: begin
        if (dmem_rvalid_i) begin
          read_data_o = dmem_rdata_i;
          RegWrite_o  = RegWrite_i;
          state_d     = IDLE;
        end else if (expired) begin
          abort   = 1'b1;
          state_d = IDLE;
        end else begin
          stall_o = 1'b1;
          clear   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    if (rst_n) begin
      state_d     = IDLE;
      dmem_req_o  = 1'b0;
      stall_o     = 1'b0;
      RegWrite_o  = 1'b0;
      read_data_o = '0;
      misalign_o  = 1'b0;
      abort       = 1'b0;
      clear       = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q   <= IDLE;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      timeout_q <= abort;
    end
  end

  mem_wait_timer #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CntW)
  ) u_wait_timer (
    .clk       (clk),
    .rst_i     (rst_n),
    .clear_i   (clear),
    .en_i      (1'b1),
    .expired_o (expired)
  );

  assign dmem_we_o    = dmem_req_o & MemWrite_i;
  assign dmem_addr_o  = alu_result_i[ADDR_W-1:0];
  assign dmem_wdata_o = write_data_i;
  assign alu_result_o = alu_result_i;
  assign write_addr_o = write_addr_i;
  assign MemtoReg_o   = MemtoReg_i;
  assign timeout_o    = timeout_q;

endmodule
